energy_step_seq: RTL and testbench

- Sequencer that sits directly upstream of the energy monitor's step counter.
- Accepts the counter configuration and new spin-vector evaluation requests.
- Drives the counter's config handshake, recount and step enables, and converts the counter value into a fetch-address stream for the weight/spin reader.
- Reports one completion token per evaluation, carrying the beat count and the downstream stall count.

---
 rtl/energy_step_seq_if.sv | 36 +++
 rtl/energy_step_seq.sv | 85 ++++++++
 tb/tb_energy_step_seq.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/energy_step_seq_if.sv
// rtl/energy_step_seq_if.sv - handshake bundle between the step sequencer, its counter and the fetch/done consumers
interface energy_step_seq_if #(
    parameter int COUNTER_BITWIDTH = 8,
    parameter int STALL_BITWIDTH   = 16
);
    logic                        config_valid_i;
    logic [COUNTER_BITWIDTH-1:0] config_counter_i;
    logic                        config_ready_o;
    logic                        spin_valid_i;
    logic                        spin_ready_o;
    logic                        recount_en_o;
    logic                        step_en_o;
    logic [COUNTER_BITWIDTH-1:0] counter_q_i;
    logic                        counter_ready_i;
    logic                        addr_valid_o;
    logic [COUNTER_BITWIDTH-1:0] addr_o;
    logic                        addr_ready_i;
    logic                        done_valid_o;
    logic [COUNTER_BITWIDTH-1:0] done_beats_o;
    logic [STALL_BITWIDTH-1:0]   done_stalls_o;
    logic                        done_ready_i;

    modport master (
        input  config_valid_i, config_counter_i, spin_valid_i,
               counter_q_i, counter_ready_i, addr_ready_i, done_ready_i,
        output config_ready_o, spin_ready_o, recount_en_o, step_en_o,
               addr_valid_o, addr_o, done_valid_o, done_beats_o, done_stalls_o
    );

    modport slave (
        output config_valid_i, config_counter_i, spin_valid_i,
               counter_q_i, counter_ready_i, addr_ready_i, done_ready_i,
        input  config_ready_o, spin_ready_o, recount_en_o, step_en_o,
               addr_valid_o, addr_o, done_valid_o, done_beats_o, done_stalls_o
    );
endinterface

// File: rtl/energy_step_seq.sv
// rtl/energy_step_seq.sv - sequences one spin evaluation: counter recount/step, fetch addresses, completion token
module energy_step_seq #(
    parameter int COUNTER_BITWIDTH = 8,
    parameter int STALL_BITWIDTH   = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    energy_step_seq_if.master  bus
);
    typedef enum logic [1:0] {
        ST_UNCFG = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [COUNTER_BITWIDTH-1:0] limit_q;
    logic [COUNTER_BITWIDTH-1:0] beat_q;
    logic [STALL_BITWIDTH-1:0]   stall_q;

    logic config_ready, spin_ready, done_valid, addr_valid;
    logic cfg_hs, spin_hs, done_hs, step, stall, run_end;

    assign config_ready = en_i & ((state_q == ST_UNCFG) | (state_q == ST_IDLE));
    assign cfg_hs       = config_ready & bus.config_valid_i;
    // Config has priority over a same-cycle spin request.
    assign spin_ready   = en_i & (state_q == ST_IDLE) & ~bus.config_valid_i;
    assign spin_hs      = spin_ready & bus.spin_valid_i;

    // Beats track the counter 1:1, so also stop on the registered limit in case the counter flag lags.
    assign run_end      = bus.counter_ready_i | (beat_q == limit_q);
    assign addr_valid   = en_i & (state_q == ST_RUN) & ~run_end;
    assign step         = addr_valid & bus.addr_ready_i;
    assign stall        = addr_valid & ~bus.addr_ready_i;
    assign done_valid   = en_i & (state_q == ST_DONE);
    assign done_hs      = done_valid & bus.done_ready_i;

    assign bus.config_ready_o = config_ready;
    assign bus.spin_ready_o   = spin_ready;
    assign bus.recount_en_o   = spin_hs;
    assign bus.step_en_o      = step;
    assign bus.addr_valid_o   = addr_valid;
    assign bus.addr_o         = bus.counter_q_i;
    assign bus.done_valid_o   = done_valid;
    assign bus.done_beats_o   = beat_q;
    assign bus.done_stalls_o  = stall_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNCFG: if (cfg_hs) state_d = ST_IDLE;
            ST_IDLE:  if (!cfg_hs && spin_hs) state_d = ST_RUN;
            ST_RUN:   if (en_i && run_end) state_d = ST_DONE;
            ST_DONE:  if (done_hs) state_d = ST_IDLE;
            default:  state_d = ST_UNCFG;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_UNCFG;
            limit_q <= '0;
            beat_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_hs) begin
                limit_q <= bus.config_counter_i;
            end
            if (spin_hs) begin
                beat_q  <= '0;
                stall_q <= '0;
            end else begin
                if (step) begin
                    beat_q <= beat_q + 1'b1;
                end
                if (stall && (stall_q != {STALL_BITWIDTH{1'b1}})) begin
                    stall_q <= stall_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_energy_step_seq.sv
// tb/tb_energy_step_seq.sv - directed bench with a transaction-level model and a cycle compare process
module tb_energy_step_seq;
    localparam int CW = 8;
    localparam int SW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    energy_step_seq_if #(.COUNTER_BITWIDTH(CW), .STALL_BITWIDTH(SW)) bus ();

    energy_step_seq #(.COUNTER_BITWIDTH(CW), .STALL_BITWIDTH(SW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (en),
        .bus    (bus)
    );

    // Step counter the sequencer drives: clears on recount, advances on step.
    logic [CW-1:0] cnt_q, cnt_limit;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            cnt_limit <= '0;
        end else begin
            if (bus.config_valid_i && bus.config_ready_o) cnt_limit <= bus.config_counter_i;
            if (bus.recount_en_o) cnt_q <= '0;
            else if (bus.step_en_o) cnt_q <= cnt_q + 1'b1;
        end
    end
    assign bus.counter_q_i     = cnt_q;
    assign bus.counter_ready_i = (cnt_q == cnt_limit);

    // Evaluation-level model: an evaluation issues `limit` addresses, then one idle cycle, then a token.
    bit m_configured, m_in_eval, m_done_pend;
    int m_limit, m_issued, m_stalls;
    logic exp_config_ready, exp_spin_ready, exp_addr_valid, exp_done_valid;

    always_comb begin
        exp_config_ready = en && !m_in_eval && !m_done_pend;
        exp_spin_ready   = exp_config_ready && m_configured && !bus.config_valid_i;
        exp_addr_valid   = en && m_in_eval && (m_issued < m_limit);
        exp_done_valid   = en && m_done_pend;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_configured <= 0; m_in_eval <= 0; m_done_pend <= 0;
            m_limit <= 0; m_issued <= 0; m_stalls <= 0;
        end else if (en) begin
            if (exp_config_ready && bus.config_valid_i) begin
                m_limit      <= int'(bus.config_counter_i);
                m_configured <= 1;
            end
            if (exp_spin_ready && bus.spin_valid_i) begin
                m_in_eval <= 1; m_issued <= 0; m_stalls <= 0;
            end else if (m_in_eval) begin
                if (m_issued >= m_limit) begin
                    m_in_eval <= 0; m_done_pend <= 1;
                end else if (bus.addr_ready_i) m_issued <= m_issued + 1;
                else if (m_stalls < 65535) m_stalls <= m_stalls + 1;
            end
            if (m_done_pend && bus.done_ready_i) m_done_pend <= 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_config_ready", 32'(bus.config_ready_o), 32'(exp_config_ready));
        chk("m_spin_ready",   32'(bus.spin_ready_o),   32'(exp_spin_ready));
        chk("m_recount",      32'(bus.recount_en_o),   32'(exp_spin_ready && bus.spin_valid_i));
        chk("m_addr_valid",   32'(bus.addr_valid_o),   32'(exp_addr_valid));
        chk("m_step",         32'(bus.step_en_o),      32'(exp_addr_valid && bus.addr_ready_i));
        chk("m_done_valid",   32'(bus.done_valid_o),   32'(exp_done_valid));
        if (exp_addr_valid) chk("m_addr", 32'(bus.addr_o), 32'(m_issued % 256));
        if (exp_done_valid) begin
            chk("m_beats",  32'(bus.done_beats_o),  32'(m_issued % 256));
            chk("m_stalls", 32'(bus.done_stalls_o), 32'(m_stalls));
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic sample(); @(negedge clk); endtask

    task automatic do_config(input logic [CW-1:0] v);
        bit ok = 0;
        bus.config_valid_i = 1; bus.config_counter_i = v;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (bus.config_ready_o) begin ok = 1; break; end
            tick();
        end
        chk("cfg_accept", 32'(ok), 32'd1);
        tick();
        bus.config_valid_i = 0;
    endtask

    task automatic do_spin();
        bit ok = 0;
        bus.spin_valid_i = 1;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (bus.spin_ready_o) begin ok = 1; break; end
            tick();
        end
        chk("spin_accept", 32'(ok), 32'd1);
        chk("recount_pulse", 32'(bus.recount_en_o), 32'd1);
        tick();
        bus.spin_valid_i = 0;
    endtask

    task automatic run_addrs(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            chk("run_addr_valid", 32'(bus.addr_valid_o), 32'd1);
            chk("run_addr", 32'(bus.addr_o), 32'(i));
            tick();
        end
    endtask

    task automatic finish_eval(input int beats, input int stalls);
        sample();
        chk("end_addr_valid", 32'(bus.addr_valid_o), 32'd0);
        chk("end_done_early", 32'(bus.done_valid_o), 32'd0);
        tick();
        sample();
        chk("done_valid", 32'(bus.done_valid_o), 32'd1);
        chk("done_beats", 32'(bus.done_beats_o), 32'(beats));
        chk("done_stalls", 32'(bus.done_stalls_o), 32'(stalls));
        bus.done_ready_i = 1;
        tick();
        bus.done_ready_i = 0;
    endtask

    initial begin
        int e2[5];
        e2 = '{0, 1, 1, 1, 2};
        bus.config_valid_i = 0; bus.config_counter_i = '0; bus.spin_valid_i = 0;
        bus.addr_ready_i = 1; bus.done_ready_i = 0;

        // Reset values
        sample();
        chk("rst_config_ready", 32'(bus.config_ready_o), 32'd1);
        chk("rst_spin_ready", 32'(bus.spin_ready_o), 32'd0);
        chk("rst_done_valid", 32'(bus.done_valid_o), 32'd0);
        chk("rst_addr_valid", 32'(bus.addr_valid_o), 32'd0);
        tick();
        rst_n = 1;

        // Limit 4, no backpressure
        do_config(8'd4);
        do_spin();
        run_addrs(4);
        finish_eval(4, 0);

        // Limit 3, two stall cycles on beat 1
        do_config(8'd3);
        do_spin();
        for (int k = 0; k < 5; k++) begin
            bus.addr_ready_i = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            sample();
            chk("t2_addr_valid", 32'(bus.addr_valid_o), 32'd1);
            chk("t2_addr", 32'(bus.addr_o), 32'(e2[k]));
            chk("t2_step", 32'(bus.step_en_o), 32'(bus.addr_ready_i));
            tick();
        end
        bus.addr_ready_i = 1;
        finish_eval(3, 2);

        // Limit 0: token two cycles after the handshake
        do_config(8'd0);
        do_spin();
        finish_eval(0, 0);

        // Config/spin collision in IDLE
        bus.config_valid_i = 1; bus.config_counter_i = 8'd2; bus.spin_valid_i = 1;
        sample();
        chk("col_config_ready", 32'(bus.config_ready_o), 32'd1);
        chk("col_spin_ready", 32'(bus.spin_ready_o), 32'd0);
        chk("col_recount", 32'(bus.recount_en_o), 32'd0);
        tick();
        bus.config_valid_i = 0;
        sample();
        chk("col_spin_next", 32'(bus.spin_ready_o), 32'd1);
        tick();
        bus.spin_valid_i = 0;
        run_addrs(2);
        finish_eval(2, 0);

        // Enable dropped for 3 cycles at beat 2, then long done wait
        do_config(8'd5);
        do_spin();
        run_addrs(2);
        en = 0; bus.addr_ready_i = 0;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("frz_addr_valid", 32'(bus.addr_valid_o), 32'd0);
            chk("frz_step", 32'(bus.step_en_o), 32'd0);
            chk("frz_config_ready", 32'(bus.config_ready_o), 32'd0);
            chk("frz_addr_hold", 32'(bus.addr_o), 32'd2);
            tick();
        end
        en = 1; bus.addr_ready_i = 1;
        for (int i = 2; i < 5; i++) begin
            sample();
            chk("frz_resume_addr", 32'(bus.addr_o), 32'(i));
            tick();
        end
        sample();
        chk("frz_end_valid", 32'(bus.addr_valid_o), 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            sample();
            chk("hold_done_valid", 32'(bus.done_valid_o), 32'd1);
            chk("hold_beats", 32'(bus.done_beats_o), 32'd5);
            chk("hold_stalls", 32'(bus.done_stalls_o), 32'd0);
            tick();
        end
        bus.done_ready_i = 1;
        tick();
        bus.done_ready_i = 0;
        sample();
        chk("idle_after_done", 32'(bus.config_ready_o), 32'd1);
        chk("idle_no_done", 32'(bus.done_valid_o), 32'd0);
        tick();

        // Reset mid-RUN
        do_config(8'd6);
        do_spin();
        run_addrs(2);
        rst_n = 0;
        #1;
        chk("arst_config_ready", 32'(bus.config_ready_o), 32'd1);
        chk("arst_addr_valid", 32'(bus.addr_valid_o), 32'd0);
        chk("arst_step", 32'(bus.step_en_o), 32'd0);
        tick();
        rst_n = 1;
        bus.spin_valid_i = 1;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("uncfg_spin_ready", 32'(bus.spin_ready_o), 32'd0);
            chk("uncfg_recount", 32'(bus.recount_en_o), 32'd0);
            tick();
        end
        do_config(8'd1);
        sample();
        chk("recfg_spin_ready", 32'(bus.spin_ready_o), 32'd1);
        tick();
        bus.spin_valid_i = 0;
        run_addrs(1);
        finish_eval(1, 0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
